// File: rtl/uart_rx_fifo.sv
// UART receiver for the MIDI input: synchronised rx line, mid-bit sampling, stop-bit framing
// checks and a show-ahead byte FIFO with valid/ready output and sticky error flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 3200,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          clk_100mhz,
    input  logic                          reset_n,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow,
    output logic                          frame_err_sticky,
    input  logic                          clear_err,
    output logic [2:0]                    dbg_state_o
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    // Handshake: a byte transfers on a rising clk edge where m_valid && m_ready are both high;
    // m_data is stable while m_valid is high and m_ready is low.

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_vld_q;
    logic                   armed_q;
    logic                   rx_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // After reset the receiver only arms once the real line has propagated through the
    // synchroniser and been seen high, so a frame cut by reset is never half-received.
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '1;
            sync_vld_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            if (sync_vld_q[SYNC_STAGES-1] && rx_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        clks_q, clks_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push;

    always_comb begin
        state_d   = state_q;
        clks_d    = clks_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (armed_q && !rx_s) begin
                    state_d = S_START;
                    clks_d  = '0;
                end
            end
            S_START: begin
                if (clks_q == HALF_LAST) begin
                    clks_d  = '0;
                    idx_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clks_d = clks_q + CW'(1);
                end
            end
            S_DATA: begin
                if (clks_q == BIT_LAST) begin
                    clks_d         = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    clks_d = clks_q + CW'(1);
                end
            end
            S_STOP: begin
                if (clks_q == BIT_LAST) begin
                    clks_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = S_WAIT_HIGH;
                    end
                end else begin
                    clks_d = clks_q + CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            clks_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            clks_q  <= clks_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign dbg_state_o = state_q;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]      count_q;
    logic                 full, pop, wr_en, ovf_set;

    assign full    = (count_q == FULL_CNT);
    assign pop     = m_valid && m_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts the push.
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge clk_100mhz) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign m_valid    = (count_q != '0);
    assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;

    logic overflow_q, frame_err_sticky_q;

    // A new error in the same cycle as clear_err takes priority.
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q         <= 1'b0;
            frame_err_sticky_q <= 1'b0;
        end else begin
            overflow_q         <= ovf_set   ? 1'b1 : (clear_err ? 1'b0 : overflow_q);
            frame_err_sticky_q <= frame_err ? 1'b1 : (clear_err ? 1'b0 : frame_err_sticky_q);
        end
    end

    assign overflow         = overflow_q;
    assign frame_err_sticky = frame_err_sticky_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit: framing, glitch rejection,
// overflow, full-FIFO push/pop, async reset mid-frame and sticky flag clearing.
module tb_uart_rx_fifo;

    localparam int C = 16;

    logic       clk_100mhz = 1'b0;
    logic       reset_n;
    logic       rx;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overflow;
    logic       frame_err_sticky;
    logic       clear_err;
    logic [2:0] dbg_state;

    always #5 clk_100mhz = ~clk_100mhz;

    uart_rx_fifo #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (8),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk_100mhz      (clk_100mhz),
        .reset_n         (reset_n),
        .rx              (rx),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .fifo_count      (fifo_count),
        .frame_err       (frame_err),
        .overflow        (overflow),
        .frame_err_sticky(frame_err_sticky),
        .clear_err       (clear_err),
        .dbg_state_o     (dbg_state)
    );

    int         tests = 0;
    int         fails = 0;
    int         cycle = 0;
    int         fe_cnt = 0;
    int         mv_rise = -1;
    logic       mv_prev = 1'b0;
    logic [7:0] got_q[$];

    always @(posedge clk_100mhz) cycle++;

    // Monitor on the falling edge: accepted bytes, frame_err pulses, m_valid rise time.
    always @(negedge clk_100mhz) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back(m_data);
        if (frame_err === 1'b1) fe_cnt++;
        if (m_valid === 1'b1 && mv_prev !== 1'b1) mv_rise = cycle;
        mv_prev = m_valid;
    end

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) tick();
        end
        rx = stop;
        repeat (C) tick();
        rx = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rx = 1'b1; m_ready = 1'b1; clear_err = 1'b0;
        repeat (3) tick();
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        tests++; if ({frame_err, overflow, frame_err_sticky} !== 3'b000) begin
            fails++; $display("FAIL reset_errs: got %b want 000", {frame_err, overflow, frame_err_sticky});
        end
        tests++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        reset_n = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_single();
        int t0, fe0, lat;
        got_q.delete(); fe0 = fe_cnt; m_ready = 1'b1; mv_rise = -1;
        t0 = cycle;
        send_frame(8'h90, 1'b1);
        repeat (5) tick();
        lat = mv_rise - t0;
        tests++; if (got_q.size() != 1 || got_q[0] !== 8'h90) begin
            fails++; $display("FAIL single_data: got %0d bytes first %h want 1 byte 90", got_q.size(), got_q[0]);
        end
        tests++; if (lat < 154 || lat > 156) begin fails++; $display("FAIL single_latency: got %0d want 155+-1", lat); end
        tests++; if (fe_cnt != fe0) begin fails++; $display("FAIL single_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL single_drained: got m_valid %b want 0", m_valid); end
    endtask

    task automatic test_glitch();
        int fe0;
        got_q.delete(); fe0 = fe_cnt;
        rx = 1'b0;
        repeat (5) tick();
        tests++; if (dbg_state !== 3'd1) begin fails++; $display("FAIL glitch_start_seen: got state %0d want 1", dbg_state); end
        rx = 1'b1;
        repeat (30) tick();
        tests++; if (got_q.size() != 0) begin fails++; $display("FAIL glitch_no_push: got %0d bytes want 0", got_q.size()); end
        tests++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL glitch_idle: got state %0d want 0", dbg_state); end
        tests++; if (fe_cnt != fe0 || frame_err_sticky !== 1'b0 || overflow !== 1'b0) begin
            fails++; $display("FAIL glitch_errs: got pulses %0d sticky %b ovf %b want 0 0 0", fe_cnt - fe0, frame_err_sticky, overflow);
        end
    endtask

    task automatic test_frame_err();
        int fe0;
        got_q.delete(); fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40) tick();
        tests++; if (dbg_state !== 3'd4) begin fails++; $display("FAIL break_wait_high: got state %0d want 4", dbg_state); end
        rx = 1'b1;
        repeat (20) tick();
        send_frame(8'h45, 1'b1);
        repeat (5) tick();
        tests++; if (fe_cnt - fe0 != 1) begin fails++; $display("FAIL break_pulses: got %0d want 1", fe_cnt - fe0); end
        tests++; if (frame_err_sticky !== 1'b1) begin fails++; $display("FAIL break_sticky: got %b want 1", frame_err_sticky); end
        tests++; if (got_q.size() != 1 || got_q[0] !== 8'h45) begin
            fails++; $display("FAIL break_data: got %0d bytes first %h want 1 byte 45", got_q.size(), got_q[0]);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        got_q.delete(); m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (4) tick();
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        tests++; if (m_valid !== 1'b1 || m_data !== 8'h01) begin
            fails++; $display("FAIL ovf_head: got valid %b data %h want 1 01", m_valid, m_data);
        end
        m_ready = 1'b1;
        repeat (6) tick();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        tests++; if (got_q != exp_q) begin
            fails++; $display("FAIL ovf_order: got %0d bytes %p want %p", got_q.size(), got_q, exp_q);
        end
        tests++; if (m_valid !== 1'b0 || fifo_count !== 3'd0) begin
            fails++; $display("FAIL ovf_drained: got valid %b count %0d want 0 0", m_valid, fifo_count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q[$];
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        tests++; if (overflow !== 1'b0 || frame_err_sticky !== 1'b0) begin
            fails++; $display("FAIL clear_both: got ovf %b sticky %b want 0 0", overflow, frame_err_sticky);
        end
        got_q.delete(); m_ready = 1'b0;
        send_frame(8'h11, 1'b1); send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1); send_frame(8'h44, 1'b1);
        repeat (2) tick();
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_fill: got %0d want 4", fifo_count); end
        fork
            send_frame(8'h7F, 1'b1);
            begin
                repeat (154) tick();
                m_ready = 1'b1;
                tick();
                m_ready = 1'b0;
            end
        join
        repeat (3) tick();
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_pp_count: got %0d want 4", fifo_count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_pp_ovf: got %b want 0", overflow); end
        m_ready = 1'b1;
        repeat (6) tick();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h7F};
        tests++; if (got_q != exp_q) begin
            fails++; $display("FAIL full_pp_order: got %0d bytes %p want %p", got_q.size(), got_q, exp_q);
        end
    endtask

    task automatic test_reset_mid_frame();
        got_q.delete(); m_ready = 1'b0;
        send_frame(8'h12, 1'b1); send_frame(8'h34, 1'b1);
        repeat (2) tick();
        tests++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL rst_pre_count: got %0d want 2", fifo_count); end
        fork
            send_frame(8'hAA, 1'b1);
            begin
                repeat (60) tick();
                #2 reset_n = 1'b0;
                #1;
                tests++; if (m_valid !== 1'b0 || fifo_count !== 3'd0) begin
                    fails++; $display("FAIL rst_async: got valid %b count %0d want 0 0", m_valid, fifo_count);
                end
                tests++; if (m_data !== 8'h00 || dbg_state !== 3'd0) begin
                    fails++; $display("FAIL rst_async_state: got data %h state %0d want 00 0", m_data, dbg_state);
                end
            end
        join
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        m_ready = 1'b1;
        send_frame(8'h55, 1'b1);
        repeat (5) tick();
        tests++; if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
            fails++; $display("FAIL rst_next_frame: got %0d bytes first %h want 1 byte 55", got_q.size(), got_q[0]);
        end
    endtask

    task automatic test_clear_err();
        int fe0;
        fe0 = fe_cnt;
        fork
            begin
                clear_err = 1'b1;
                repeat (155) tick();
                clear_err = 1'b0;
            end
            send_frame(8'h3C, 1'b0);
        join
        repeat (4) tick();
        tests++; if (frame_err_sticky !== 1'b1 || fe_cnt - fe0 != 1) begin
            fails++; $display("FAIL clr_set_wins: got sticky %b pulses %0d want 1 1", frame_err_sticky, fe_cnt - fe0);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        tests++; if (frame_err_sticky !== 1'b0 || overflow !== 1'b0) begin
            fails++; $display("FAIL clr_sticky: got sticky %b ovf %b want 0 0", frame_err_sticky, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
        test_clear_err();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
